// File: rtl/simon_core_param.sv
// Iterative SIMON 2N/MN block cipher core with a stored, reusable key schedule.
// Define SIMON_UNROLL2_EN for two rounds per cycle (T must then be even).
module simon_core_param #(
  parameter int N    = 48,
  parameter int M    = 2,
  parameter int T    = 52,
  parameter int ZSEL = 2,
  parameter int Cb   = 7
) (
  input  logic                clk,
  input  logic                nR,
  input  logic                newKey,
  input  logic [M-1:0][N-1:0] KEY,
  input  logic                newData,
  input  logic                enc_dec,
  input  logic [1:0][N-1:0]   blockIN,
  input  logic                readData,
  output logic                loadKey,
  output logic                loadData,
  output logic                doneKey,
  output logic                doneData,
  output logic [2*N-1:0]      outData,
  output logic [3:0]          mode
);

  if (T < 32 || T > 72) begin : g_bad_rounds
    $error("simon_core_param: T=%0d outside 32..72", T);
  end
  if ((2 ** Cb) <= T) begin : g_bad_counter
    $error("simon_core_param: Cb=%0d too narrow for T=%0d", Cb, T);
  end
  if (M < 2 || M > 4 || ZSEL < 0 || ZSEL > 4) begin : g_bad_shape
    $error("simon_core_param: unsupported M=%0d or ZSEL=%0d", M, ZSEL);
  end
`ifdef SIMON_UNROLL2_EN
  if (T % 2 != 0) begin : g_bad_unroll
    $error("simon_core_param: two-round datapath needs even T, got %0d", T);
  end
`endif

  localparam int            KW       = $clog2(T);
  localparam logic [Cb-1:0] LAST_KEY = Cb'(T - 1);
`ifdef SIMON_UNROLL2_EN
  localparam logic [Cb-1:0] STEP     = Cb'(2);
  localparam logic [Cb-1:0] LAST_RC  = Cb'(T - 2);
`else
  localparam logic [Cb-1:0] STEP     = Cb'(1);
  localparam logic [Cb-1:0] LAST_RC  = Cb'(T - 1);
`endif
  localparam logic [N-1:0]  C3       = N'(3);

  // z sequences stored bit-reversed so that bit j is the j-th constant bit.
  localparam logic [61:0] Z_SEQ =
    (ZSEL == 0) ? 62'b01100111000011010100100010111110110011100001101010010001011111 :
    (ZSEL == 1) ? 62'b01011010000110010011111011100010101101000011001001111101110001 :
    (ZSEL == 2) ? 62'b11001101101001111110001000010100011001001011000000111011110101 :
    (ZSEL == 3) ? 62'b11110000101100111001010001001000000111101001100011010111011011 :
                  62'b11110111001001010011000011101000000100011011010110011110001011;

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    KEYEXP = 4'b0010,
    ROUND  = 4'b0100,
    HOLD   = 4'b1000
  } state_t;

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
    return rol(v, N - s);
  endfunction

  function automatic logic [2*N-1:0] round_f(input logic [N-1:0] x, input logic [N-1:0] y,
                                             input logic [N-1:0] k);
    return {y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ k, x};
  endfunction

  state_t              state_q, state_d;
  logic [Cb-1:0]       kidx_q, rc_q;
  logic [5:0]          zidx_q;
  logic                done_key_q, enc_q;
  logic [2*N-1:0]      out_q;
  logic [N-1:0]        key_ram [T];
  logic [M-1:0][N-1:0] win_q;
  logic [N-1:0]        x_q, y_q;

  logic                key_acc, data_acc;
  logic [N-1:0]        tmp, new_key;
  logic [KW-1:0]       kaddr_a;
  logic [2*N-1:0]      rnd_a, rnd_b, result;

  assign key_acc  = (state_q == IDLE) && newKey;
  // A simultaneous newKey wins; the block is simply not taken.
  assign data_acc = (state_q == IDLE) && newData && done_key_q && !newKey;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (key_acc)       state_d = KEYEXP;
        else if (data_acc) state_d = ROUND;
      end
      KEYEXP:  if (kidx_q == LAST_KEY) state_d = IDLE;
      ROUND:   if (rc_q == LAST_RC)    state_d = HOLD;
      HOLD:    if (readData)           state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // win_q[M-1] is k[i-1], win_q[0] is k[i-M]; win_q[1] is k[i-3] when M=4.
  always_comb begin
    tmp = ror(win_q[M-1], 3);
    if (M == 4) tmp = tmp ^ win_q[1];
    tmp     = tmp ^ ror(tmp, 1);
    new_key = ~win_q[0] ^ tmp ^ {{(N-1){1'b0}}, Z_SEQ[zidx_q]} ^ C3;
  end

  // Decrypt walks the schedule from k[T-1] down to k[0].
  assign kaddr_a = enc_q ? rc_q[KW-1:0] : KW'(T - 1) - rc_q[KW-1:0];
  assign rnd_a   = round_f(x_q, y_q, key_ram[kaddr_a]);
`ifdef SIMON_UNROLL2_EN
  logic [KW-1:0] kaddr_b;
  assign kaddr_b = enc_q ? rc_q[KW-1:0] + KW'(1) : KW'(T - 2) - rc_q[KW-1:0];
  assign rnd_b   = round_f(rnd_a[2*N-1:N], rnd_a[N-1:0], key_ram[kaddr_b]);
`else
  assign rnd_b   = rnd_a;
`endif
  assign result  = enc_q ? rnd_b : {rnd_b[N-1:0], rnd_b[2*N-1:N]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state_q    <= IDLE;
      kidx_q     <= '0;
      rc_q       <= '0;
      zidx_q     <= '0;
      done_key_q <= 1'b0;
      enc_q      <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (key_acc) begin
            kidx_q     <= Cb'(M);
            zidx_q     <= '0;
            done_key_q <= 1'b0;
          end else if (data_acc) begin
            rc_q  <= '0;
            enc_q <= enc_dec;
          end
        end
        KEYEXP: begin
          kidx_q <= kidx_q + Cb'(1);
          zidx_q <= (zidx_q == 6'd61) ? 6'd0 : zidx_q + 6'd1;
          if (kidx_q == LAST_KEY) done_key_q <= 1'b1;
        end
        ROUND: begin
          rc_q <= rc_q + STEP;
          if (rc_q == LAST_RC) out_q <= result;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the key RAM and round registers carry no reset; done_key_q and the FSM decide validity.
  always_ff @(posedge clk) begin
    if (key_acc) begin
      win_q <= KEY;
      for (int j = 0; j < M; j++) key_ram[KW'(j)] <= KEY[j];
    end else if (state_q == KEYEXP) begin
      win_q                   <= {new_key, win_q[M-1:1]};
      key_ram[kidx_q[KW-1:0]] <= new_key;
    end
    if (data_acc) begin
      {x_q, y_q} <= enc_dec ? blockIN : {blockIN[0], blockIN[1]};
    end else if (state_q == ROUND) begin
      {x_q, y_q} <= rnd_b;
    end
  end

  assign loadKey  = (state_q == IDLE);
  assign loadData = (state_q == IDLE) && done_key_q;
  assign doneKey  = done_key_q;
  assign doneData = (state_q == HOLD);
  assign outData  = out_q;
  assign mode     = state_q;

endmodule

// File: tb/tb_simon_core_param.sv
// Scoreboard bench for simon_core_param: a 96/96 instance and a 32/64 instance
// checked against published SIMON vectors, handshakes and mid-round reset.
module tb_simon_core_param;

  localparam logic [95:0] KEY96 = 96'h0d0c0b0a0908_050403020100;
  localparam logic [95:0] PT96  = 96'h2072616c6c69_702065687420;
  localparam logic [95:0] CT96  = 96'h602807a462b4_69063d8ff082;
  localparam logic [95:0] KEY32 = 96'h1918_1110_0908_0100;
  localparam logic [95:0] PT32  = 96'h6565_6877;
  localparam logic [95:0] CT32  = 96'hc69b_e9bb;
`ifdef SIMON_UNROLL2_EN
  localparam int LAT96 = 26;
  localparam int LAT32 = 16;
`else
  localparam int LAT96 = 52;
  localparam int LAT32 = 32;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nR, newKey, newData, enc_dec, readData, use32;
  logic [95:0] key_v, blk_v;

  logic [1:0][47:0] key96, blk96;
  logic [3:0][15:0] key32;
  logic [1:0][15:0] blk32;
  logic             lk96, ld96, dk96, dd96, lk32, ld32, dk32, dd32;
  logic [95:0]      out96;
  logic [31:0]      out32;
  logic [3:0]       mode96, mode32;

  assign key96 = key_v;
  assign blk96 = blk_v;
  assign key32 = key_v[63:0];
  assign blk32 = blk_v[31:0];

  simon_core_param u_dut (
    .clk(clk), .nR(nR), .newKey(newKey & ~use32), .KEY(key96),
    .newData(newData & ~use32), .enc_dec(enc_dec), .blockIN(blk96),
    .readData(readData & ~use32), .loadKey(lk96), .loadData(ld96),
    .doneKey(dk96), .doneData(dd96), .outData(out96), .mode(mode96)
  );

  simon_core_param #(.N(16), .M(4), .T(32), .ZSEL(0), .Cb(6)) u_dut32 (
    .clk(clk), .nR(nR), .newKey(newKey & use32), .KEY(key32),
    .newData(newData & use32), .enc_dec(enc_dec), .blockIN(blk32),
    .readData(readData & use32), .loadKey(lk32), .loadData(ld32),
    .doneKey(dk32), .doneData(dd32), .outData(out32), .mode(mode32)
  );

  logic        lk_v, ld_v, dk_v, dd_v;
  logic [95:0] out_v;
  logic [3:0]  mode_v;
  assign lk_v   = use32 ? lk32 : lk96;
  assign ld_v   = use32 ? ld32 : ld96;
  assign dk_v   = use32 ? dk32 : dk96;
  assign dd_v   = use32 ? dd32 : dd96;
  assign out_v  = use32 ? 96'(out32) : out96;
  assign mode_v = use32 ? mode32 : mode96;

  int          n_vec = 0;
  int          n_err = 0;
  logic [95:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_key(input logic [95:0] key, input bit with_data, input int lat);
    int cyc;
    @(negedge clk);
    key_v  = key;
    newKey = 1'b1;
    if (with_data) begin
      blk_v   = PT96;
      enc_dec = 1'b1;
      newData = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    newKey  = 1'b0;
    newData = 1'b0;
    check("keyexp_mode", 128'(mode_v), 128'(4'b0010));
    check("keyexp_flags", 128'({lk_v, ld_v, dk_v}), 128'(3'b000));
    cyc = 0;
    while (!dk_v && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("key_latency", 128'(cyc), 128'(lat));
    check("key_done_flags", 128'({lk_v, ld_v, dk_v}), 128'(3'b111));
    check("key_done_mode", 128'(mode_v), 128'(4'b0001));
  endtask

  task automatic do_data(input logic [95:0] blk, input logic enc, input logic [95:0] exp,
                         input int lat, input int hold, input bit poke);
    int          cyc;
    logic [95:0] exp_blk;
    exp_q.push_back(exp);
    @(negedge clk);
    blk_v   = blk;
    enc_dec = enc;
    newData = 1'b1;
    @(posedge clk);
    @(negedge clk);
    newData = 1'b0;
    check("round_mode", 128'(mode_v), 128'(4'b0100));
    cyc = 0;
    while (!dd_v && cyc < 200) begin
      if (poke && cyc == 3) begin
        key_v  = ~key_v;
        newKey = 1'b1;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (newKey) begin
        newKey = 1'b0;
        key_v  = ~key_v;
        check("round_ignores_key", 128'({mode_v, dk_v}), 128'({4'b0100, 1'b1}));
      end
    end
    check("data_latency", 128'(cyc), 128'(lat));
    exp_blk = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("out_data", 128'(out_v), 128'(exp_blk));
    check("hold_flags", 128'({dd_v, ld_v, lk_v, mode_v}), 128'({3'b100, 4'b1000}));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_stable", 128'({dd_v, mode_v, out_v}), 128'({1'b1, 4'b1000, exp_blk}));
    end
    readData = 1'b1;
    @(posedge clk);
    @(negedge clk);
    readData = 1'b0;
    check("release_flags", 128'({dd_v, ld_v, lk_v, dk_v}), 128'(4'b0111));
    check("release_mode", 128'(mode_v), 128'(4'b0001));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    nR       = 1'b1;
    newKey   = 1'b0;
    newData  = 1'b0;
    enc_dec  = 1'b0;
    readData = 1'b0;
    use32    = 1'b0;
    key_v    = '0;
    blk_v    = '0;
    #2 nR = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_flags96", 128'({lk96, ld96, dk96, dd96, mode96}), 128'({4'b1000, 4'b0001}));
    check("reset_out96", 128'(out96), 128'(0));
    check("reset_flags32", 128'({lk32, ld32, dk32, dd32, mode32}), 128'({4'b1000, 4'b0001}));
    nR = 1'b1;

    // A block offered before any key must be ignored.
    @(negedge clk);
    blk_v   = PT96;
    enc_dec = 1'b1;
    newData = 1'b1;
    @(posedge clk);
    @(negedge clk);
    newData = 1'b0;
    check("nokey_mode", 128'(mode_v), 128'(4'b0001));
    check("nokey_flags", 128'({lk_v, ld_v, dk_v, dd_v}), 128'(4'b1000));

    do_key(KEY96, 1'b0, 50);
    do_data(PT96, 1'b1, CT96, LAT96, 10, 1'b1);
    do_data(CT96, 1'b0, PT96, LAT96, 0, 1'b0);
    do_key(KEY96, 1'b1, 50);
    do_data(PT96, 1'b1, CT96, LAT96, 0, 1'b0);

    // Asynchronous reset in the middle of a block.
    @(negedge clk);
    blk_v   = PT96;
    enc_dec = 1'b1;
    newData = 1'b1;
    @(posedge clk);
    @(negedge clk);
    newData = 1'b0;
    repeat (20) @(posedge clk);
    #2 nR = 1'b0;
    #1;
    check("midreset_flags", 128'({lk_v, ld_v, dk_v, dd_v, mode_v}), 128'({4'b1000, 4'b0001}));
    check("midreset_out", 128'(out_v), 128'(0));
    @(negedge clk);
    nR = 1'b1;
    @(negedge clk);
    newData = 1'b1;
    @(posedge clk);
    @(negedge clk);
    newData = 1'b0;
    repeat (3) @(negedge clk);
    check("postreset_nodata", 128'({mode_v, dd_v, dk_v}), 128'({4'b0001, 2'b00}));

    use32 = 1'b1;
    do_key(KEY32, 1'b0, 28);
    do_data(PT32, 1'b1, CT32, LAT32, 2, 1'b0);
    do_data(CT32, 1'b0, PT32, LAT32, 0, 1'b0);

    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
